// File: rtl/log_encoder_pkg.sv
// Shared item type codes, Avalon tag words, FSM states and the buffered item layout
// for the log word encoder.
package log_encoder_pkg;

    localparam logic [2:0] TYPE_CHAR     = 3'd0;
    localparam logic [2:0] TYPE_INT      = 3'd1;
    localparam logic [2:0] TYPE_FIXED    = 3'd2;
    localparam logic [2:0] TYPE_CLKCOUNT = 3'd3;
    localparam logic [2:0] TYPE_END      = 3'd4;

    localparam logic [31:0] TAG_CLKCOUNT = 32'hFFFF_FFFC;
    localparam logic [31:0] TAG_INT      = 32'hFFFF_FFFD;
    localparam logic [31:0] TAG_FIXED    = 32'hFFFF_FFFE;
    localparam logic [31:0] TAG_END      = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_TAG,
        GAP_TAG,
        WR_DATA,
        GAP,
        HALT
    } state_e;

    typedef struct packed {
        logic [2:0]  typ;
        logic [31:0] dat;
    } item_t;

endpackage

// File: rtl/log_fifo.sv
// Synchronous count-based FIFO: one cycle from push to visible head, show-ahead read.
// Pushes are refused while full; flush empties it in one cycle.
module log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = wr_vld && !full;
        do_pop   = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/log_word_encoder.sv
// Turns buffered log items into Avalon-MM write words; first write starts two edges after push.
// avm_waitrequest stalls the current word; in_ready drops when the buffer is full or after END.
module log_word_encoder
    import log_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_type,
    input  logic [31:0]           in_data,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    input  logic                  avm_waitrequest,
    output logic                  done,
    output logic                  illegal
);

    state_e      state_q, state_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  typ_q, typ_d;
    logic        illegal_q, illegal_d;

    item_t in_item;
    item_t head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_pop;

    assign in_item = '{typ: in_type, dat: in_data};

    log_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(item_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (done),
        .wr_vld  (in_valid && in_ready),
        .wr_dat  (in_item),
        .rd_en   (fifo_pop),
        .rd_dat  (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign done          = (state_q == HALT);
    assign in_ready      = !fifo_full && !done;
    assign avm_write     = (state_q == WR_TAG) || (state_q == WR_DATA);
    assign avm_writedata = wdata_q;
    assign avm_address   = '0;
    assign illegal       = illegal_q;

    always_comb begin
        state_d   = state_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        typ_d     = typ_q;
        illegal_d = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    typ_d    = head.typ;
                    data_d   = head.dat;
                    case (head.typ)
                        TYPE_CHAR: begin
                            wdata_d = {24'h0, head.dat[7:0]};
                            state_d = WR_DATA;
                        end
                        TYPE_INT: begin
                            wdata_d = TAG_INT;
                            state_d = WR_TAG;
                        end
                        TYPE_FIXED: begin
                            wdata_d = TAG_FIXED;
                            state_d = WR_TAG;
                        end
                        TYPE_CLKCOUNT: begin
                            wdata_d = TAG_CLKCOUNT;
                            state_d = WR_TAG;
                        end
                        TYPE_END: begin
                            wdata_d = TAG_END;
                            state_d = WR_TAG;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            WR_TAG: begin
                if (!avm_waitrequest) begin
                    case (typ_q)
                        TYPE_INT, TYPE_FIXED: begin
                            // Payload is staged during the gap so it is stable when write rises.
                            wdata_d = data_q;
                            state_d = GAP_TAG;
                        end
                        TYPE_CLKCOUNT: state_d = GAP;
                        default:       state_d = HALT;
                    endcase
                end
            end
            GAP_TAG: state_d = WR_DATA;
            WR_DATA: begin
                if (!avm_waitrequest) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wdata_q   <= '0;
            data_q    <= '0;
            typ_q     <= TYPE_CHAR;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            typ_q     <= typ_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_log_word_encoder.sv
// Directed bench for log_word_encoder: single-item vector table plus stall, overflow,
// illegal-type, END/halt and mid-write reset sequences.
module tb_log_word_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = 3'd0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        done;
    logic        illegal;

    log_word_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_type         (in_type),
        .in_data         (in_data),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .done            (done),
        .illegal         (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs[$];
    int          runs[$];
    int          lows[$];
    int          ill_cnt = 0;
    int          hi_cycles = 0;
    int          accepted = 0;
    bit          in_run = 0;
    bit          had_prev = 0;
    int          run_len = 0;
    int          low_len = 0;
    logic [31:0] prev_wd = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int k);
        return (obs.size() > k) ? obs[k] : 32'hDEAD_BEEF;
    endfunction

    // Bus monitor, sampled on the falling edge: a word completes on the next rising edge
    // whenever write is high and waitrequest low.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_run   = 0;
            had_prev = 0;
            run_len  = 0;
            low_len  = 0;
        end else begin
            if (illegal) ill_cnt++;
            if (avm_write) begin
                hi_cycles++;
                if (!in_run) begin
                    if (had_prev) begin
                        lows.push_back(low_len);
                        checks++;
                        if (low_len == 0) begin
                            errors++;
                            $display("FAIL write_gap: write re-asserted after %0d low cycles, expected >=1", low_len);
                        end
                    end
                    in_run  = 1;
                    run_len = 0;
                end else begin
                    check("wdata_stable", avm_writedata, prev_wd);
                end
                run_len++;
                prev_wd = avm_writedata;
                if (!avm_waitrequest) begin
                    obs.push_back(avm_writedata);
                    runs.push_back(run_len);
                    in_run   = 0;
                    had_prev = 1;
                    low_len  = 0;
                end
            end else begin
                if (in_run) begin
                    checks++;
                    errors++;
                    $display("FAIL write_abandoned: write dropped after %0d stalled cycles, expected held", run_len);
                end
                in_run = 0;
                low_len++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        obs.delete();
        runs.delete();
        lows.delete();
        ill_cnt   = 0;
        hi_cycles = 0;
        had_prev  = 0;
        low_len   = 0;
    endtask

    // Offers one item from posedge+1 and returns posedge+1 after the accepting edge.
    task automatic push_item(input logic [2:0] t, input logic [31:0] d, input int budget, output bit ok);
        ok       = 0;
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                accepted++;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] t, input logic [31:0] d);
        bit ok;
        push_item(t, d, 200, ok);
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (obs.size() >= n) break;
            tick();
        end
    endtask

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] dat;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        int          ill;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        vecs[0] = '{3'd0, 32'h0000_0041, 1, 32'h0000_0041, 32'h0, 0};
        vecs[1] = '{3'd0, 32'hFFFF_FF7A, 1, 32'h0000_007A, 32'h0, 0};
        vecs[2] = '{3'd1, 32'd1234,      2, 32'hFFFF_FFFD, 32'h0000_04D2, 0};
        vecs[3] = '{3'd2, 32'd314159,    2, 32'hFFFF_FFFE, 32'h0004_CB2F, 0};
        vecs[4] = '{3'd3, 32'h1234_5678, 1, 32'hFFFF_FFFC, 32'h0, 0};
        vecs[5] = '{3'd1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0};
        vecs[6] = '{3'd6, 32'h0000_0055, 0, 32'h0, 32'h0, 1};
        vecs[7] = '{3'd5, 32'h0000_0066, 0, 32'h0, 32'h0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_wdata", avm_writedata, 32'h0);
        check("rst_addr", 32'(avm_address), 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single items, no stalls
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            push(vecs[i].typ, vecs[i].dat);
            check($sformatf("v%0d_write_at_push", i), 32'(avm_write), 32'd0);
            tick();
            check($sformatf("v%0d_write_latency", i), 32'(avm_write), 32'(vecs[i].nw > 0));
            repeat (10) tick();
            check($sformatf("v%0d_nwords", i), 32'(obs.size()), 32'(vecs[i].nw));
            if (vecs[i].nw >= 1) check($sformatf("v%0d_w0", i), word_at(0), vecs[i].w0);
            if (vecs[i].nw >= 2) check($sformatf("v%0d_w1", i), word_at(1), vecs[i].w1);
            check($sformatf("v%0d_hi_cycles", i), 32'(hi_cycles), 32'(vecs[i].nw));
            check($sformatf("v%0d_illegal", i), 32'(ill_cnt), 32'(vecs[i].ill));
            check($sformatf("v%0d_done", i), 32'(done), 32'd0);
        end

        // INT with tag stalled for three cycles
        clear_mon();
        avm_waitrequest = 1'b1;
        push(3'd1, 32'd1234);
        tick();
        check("stall_tag_write", 32'(avm_write), 32'd1);
        check("stall_tag_wdata", avm_writedata, 32'hFFFF_FFFD);
        repeat (3) tick();
        avm_waitrequest = 1'b0;
        repeat (8) tick();
        check("stall_nwords", 32'(obs.size()), 32'd2);
        check("stall_w0", word_at(0), 32'hFFFF_FFFD);
        check("stall_w1", word_at(1), 32'h0000_04D2);
        check("stall_tag_len", 32'((runs.size() > 0) ? runs[0] : -1), 32'd4);
        check("stall_data_len", 32'((runs.size() > 1) ? runs[1] : -1), 32'd1);
        check("stall_gap_len", 32'((lows.size() > 0) ? lows[0] : -1), 32'd1);

        // Six CHARs against a stalled bus: 4 buffered + 1 in flight
        clear_mon();
        accepted = 0;
        avm_waitrequest = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++) push(3'd0, 32'h61 + 32'(k));
            end
            begin
                repeat (12) tick();
                check("ovf_accepted", 32'(accepted), 32'd5);
                check("ovf_in_ready", 32'(in_ready), 32'd0);
                check("ovf_no_words", 32'(obs.size()), 32'd0);
                check("ovf_held_wdata", avm_writedata, 32'h0000_0061);
                avm_waitrequest = 1'b0;
            end
        join
        wait_words(6, 60);
        repeat (4) tick();
        check("ovf_nwords", 32'(obs.size()), 32'd6);
        for (int k = 0; k < 6; k++) check($sformatf("ovf_w%0d", k), word_at(k), 32'h61 + 32'(k));
        check("ovf_gaps", 32'(lows.size()), 32'd5);

        // Illegal type followed by a CHAR
        clear_mon();
        push(3'd6, 32'h0);
        push(3'd0, 32'h42);
        repeat (12) tick();
        check("ill_nwords", 32'(obs.size()), 32'd1);
        check("ill_w0", word_at(0), 32'h0000_0042);
        check("ill_pulses", 32'(ill_cnt), 32'd1);

        // Reset during the data phase of an INT
        clear_mon();
        avm_waitrequest = 1'b1;
        push(3'd1, 32'h0000_BEEF);
        tick();
        avm_waitrequest = 1'b0;
        tick();
        avm_waitrequest = 1'b1;
        tick();
        check("mrst_data_write", 32'(avm_write), 32'd1);
        check("mrst_data_wdata", avm_writedata, 32'h0000_BEEF);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_write_drop", 32'(avm_write), 32'd0);
        check("mrst_wdata_clr", avm_writedata, 32'h0);
        check("mrst_done", 32'(done), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        tick();
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        clear_mon();
        push(3'd0, 32'h43);
        repeat (10) tick();
        check("mrst_nwords", 32'(obs.size()), 32'd1);
        check("mrst_w0", word_at(0), 32'h0000_0043);
        check("mrst_write_idle", 32'(avm_write), 32'd0);

        // FIXED, CLKCOUNT, END with a trailing CHAR queued behind END
        clear_mon();
        push(3'd2, 32'd314159);
        push(3'd3, 32'h0);
        push(3'd4, 32'h0);
        push(3'd0, 32'h79);
        wait_words(4, 60);
        repeat (5) tick();
        check("halt_done", 32'(done), 32'd1);
        check("halt_in_ready", 32'(in_ready), 32'd0);
        check("halt_write", 32'(avm_write), 32'd0);
        push_item(3'd0, 32'h78, 20, ok);
        check("halt_x_refused", 32'(ok), 32'd0);
        repeat (5) tick();
        check("halt_nwords", 32'(obs.size()), 32'd4);
        check("halt_w0", word_at(0), 32'hFFFF_FFFE);
        check("halt_w1", word_at(1), 32'h0004_CB2F);
        check("halt_w2", word_at(2), 32'hFFFF_FFFC);
        check("halt_w3", word_at(3), 32'hFFFF_FFFF);
        check("halt_done_sticky", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
